// File: rtl/psm_controller_multi_if.sv
// Control-side and gate-side signal bundle of the PSM generator.
// The master modport is the register-file side; the slave modport is the generator.
interface psm_controller_multi_if #(
    parameter int CNT_W  = 16,
    parameter int N_LEGS = 4,
    parameter int DT_W   = 8
);
    logic                     en;
    logic                     kill;
    logic                     sync;
    logic [CNT_W-1:0]         period;
    logic [N_LEGS*CNT_W-1:0]  phase;
    logic [DT_W-1:0]          deadtime;
    logic [2*N_LEGS-1:0]      psm;
    logic [CNT_W-1:0]         cnt;
    logic                     update;
    logic                     run;

    modport master (
        output en, kill, sync, period, phase, deadtime,
        input  psm, cnt, update, run
    );

    modport slave (
        input  en, kill, sync, period, phase, deadtime,
        output psm, cnt, update, run
    );
endinterface

// File: rtl/psm_controller_multi.sv
// Phase-shift modulator: one sawtooth carrier, N legs of 50% square waves with per-leg phase and deadtime.
// Gate edges follow the carrier by 2 clocks (plus deadtime on turn-on); no backpressure, inputs are sampled at carrier events.
module psm_controller_multi #(
    parameter int CNT_W      = 16,
    parameter int N_LEGS     = 4,
    parameter int DT_W       = 8,
    parameter int MIN_PERIOD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    psm_controller_multi_if.slave bus
);
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  per_sh;
    logic [CNT_W-1:0]  half_sh;
    logic [CNT_W-1:0]  per_new;
    logic [CNT_W-1:0]  per_last;
    logic [CNT_W-1:0]  ph_sh  [N_LEGS];
    logic [CNT_W-1:0]  ph_new [N_LEGS];
    logic              load;
    logic              wrap;
    logic              clr;
    logic [N_LEGS-1:0] s_nxt;
    logic [N_LEGS-1:0] s;
    logic              s_vld;
    logic              armed;

    assign per_new  = (bus.period < MIN_P) ? MIN_P : bus.period;
    assign per_last = per_new - 1'b1;
    assign wrap     = (cnt == per_sh - 1'b1);

    for (genvar k = 0; k < N_LEGS; k++) begin : g_clamp
        assign ph_new[k] = (bus.phase[k*CNT_W +: CNT_W] > per_last) ? per_last
                                                                     : bus.phase[k*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.en) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                // A sync landing on the wrap is still a single load event.
                if (bus.sync || wrap) begin
                    cnt_nxt = '0;
                    load    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
                if (!bus.en) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (bus.kill) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh  <= '0;
            half_sh <= '0;
            for (int k = 0; k < N_LEGS; k++) begin
                ph_sh[k] <= '0;
            end
        end else if (load) begin
            per_sh  <= per_new;
            half_sh <= per_new >> 1;
            for (int k = 0; k < N_LEGS; k++) begin
                ph_sh[k] <= ph_new[k];
            end
        end
    end

    assign bus.cnt    = cnt;
    assign bus.run    = (state != IDLE);
    assign bus.update = load;

    // Gates are dropped on the same edge the FSM enters (or sits in) IDLE.
    assign clr = (state == IDLE) || (state_nxt == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            s_vld <= 1'b0;
        end else begin
            s     <= (state != IDLE) ? s_nxt : '0;
            s_vld <= (state != IDLE);
        end
    end

    // armed=0 makes the first valid reference count as a change, so the first turn-on also waits out deadtime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (clr) begin
            armed <= 1'b0;
        end else if (s_vld) begin
            armed <= 1'b1;
        end
    end

    for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
        logic [CNT_W:0]  c_ext;
        logic [CNT_W:0]  p_ext;
        logic [CNT_W:0]  d;
        logic [1:0]      gate;
        logic [DT_W-1:0] dt;
        logic            s_last;

        assign c_ext    = {1'b0, cnt};
        assign p_ext    = {1'b0, ph_sh[k]};
        assign d        = (c_ext >= p_ext) ? (c_ext - p_ext) : (c_ext + {1'b0, per_sh} - p_ext);
        assign s_nxt[k] = (d < {1'b0, half_sh});

        // gate[0] = high switch, gate[1] = low switch; only {0,0}, {0,1}, {1,0} are ever loaded.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                gate   <= 2'b00;
                dt     <= '0;
                s_last <= 1'b0;
            end else if (clr) begin
                gate   <= 2'b00;
                dt     <= '0;
                s_last <= 1'b0;
            end else if (!s_vld) begin
                gate <= 2'b00;
                dt   <= '0;
            end else if (!armed || (s[k] != s_last)) begin
                s_last <= s[k];
                if (bus.deadtime == '0) begin
                    gate <= {!s[k], s[k]};
                    dt   <= '0;
                end else begin
                    gate <= 2'b00;
                    dt   <= bus.deadtime;
                end
            end else if (dt > 1) begin
                dt <= dt - 1'b1;
            end else begin
                dt   <= '0;
                gate <= {!s[k], s[k]};
            end
        end

        assign bus.psm[2*k +: 2] = gate;
    end
endmodule

// File: tb/tb_psm_controller_multi.sv
// Randomised and directed bench for psm_controller_multi against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_psm_controller_multi;
    localparam int CNT_W  = 16;
    localparam int N_LEGS = 4;
    localparam int DT_W   = 8;
    localparam int MINP   = 8;
    localparam int MAXC   = 40000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psm_controller_multi_if #(.CNT_W(CNT_W), .N_LEGS(N_LEGS), .DT_W(DT_W)) bus ();

    psm_controller_multi #(
        .CNT_W(CNT_W), .N_LEGS(N_LEGS), .DT_W(DT_W), .MIN_PERIOD(MINP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 = idle, 1 = run, 2 = stop. rh holds the ideal leg level per cycle (-1 while idle).
    int m_state = 0;
    int m_cnt = 0;
    int m_P = 0;
    int m_H = 0;
    int m_ph [N_LEGS];
    int cyc = 0;
    int shist [MAXC];
    int rh [N_LEGS][MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_load();
        int v;
        m_P = (int'(bus.period) < MINP) ? MINP : int'(bus.period);
        m_H = m_P / 2;
        for (int k = 0; k < N_LEGS; k++) begin
            v = int'(bus.phase[k*CNT_W +: CNT_W]);
            m_ph[k] = (v > m_P - 1) ? m_P - 1 : v;
        end
    endtask

    // Entered just after a falling edge with this cycle's inputs applied; returns at the next falling edge.
    task automatic cycle();
        logic [2*N_LEGS-1:0] ep;
        logic eu;
        int hi, lo, dtv;
        #2;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1);
        end
        shist[cyc] = m_state;
        for (int k = 0; k < N_LEGS; k++) begin
            rh[k][cyc] = (m_state != 0) ? (((m_cnt - m_ph[k] + m_P) % m_P) < m_H ? 1 : 0) : -1;
        end
        ep  = '0;
        dtv = int'(bus.deadtime);
        // A gate is on once the ideal level has held steady for deadtime+1 samples, seen 2 clocks late.
        if (cyc >= 2 && m_state != 0 && shist[cyc-1] != 0) begin
            for (int k = 0; k < N_LEGS; k++) begin
                hi = 1;
                lo = 1;
                for (int j = cyc - 2 - dtv; j <= cyc - 2; j++) begin
                    if (j < 0 || rh[k][j] != 1) hi = 0;
                    if (j < 0 || rh[k][j] != 0) lo = 0;
                end
                ep[2*k]   = (hi != 0);
                ep[2*k+1] = (lo != 0);
            end
        end
        eu = !bus.kill && ((m_state == 0 && bus.en) ||
                           (m_state == 1 && (bus.sync || m_cnt == m_P - 1)));
        chk("psm", 32'(bus.psm), 32'(ep));
        chk("cnt", 32'(bus.cnt), 32'(m_cnt));
        chk("run", 32'(bus.run), 32'(m_state != 0));
        chk("update", 32'(bus.update), 32'(eu));
        for (int k = 0; k < N_LEGS; k++) begin
            chk("overlap", 32'(bus.psm[2*k] & bus.psm[2*k+1]), 32'(0));
        end
        if (bus.kill) begin
            m_state = 0;
            m_cnt   = 0;
        end else begin
            case (m_state)
                0: begin
                    m_cnt = 0;
                    if (bus.en) begin
                        model_load();
                        m_state = 1;
                    end
                end
                1: begin
                    if (bus.sync || m_cnt == m_P - 1) begin
                        m_cnt = 0;
                        model_load();
                    end else begin
                        m_cnt++;
                    end
                    if (!bus.en) m_state = 2;
                end
                default: begin
                    if (m_cnt == m_P - 1) begin
                        m_cnt   = 0;
                        m_state = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic step_to_cnt(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_state == 1 && m_cnt == target) return;
            cycle();
        end
        chk("reach_cnt", 32'(bus.cnt), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.kill = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_state == 0) return;
            cycle();
        end
        chk("idle_timeout", 32'(bus.run), 32'(0));
    endtask

    task automatic set_phase(input int p0, input int p1, input int p2, input int p3);
        bus.phase[0*CNT_W +: CNT_W] = CNT_W'(p0);
        bus.phase[1*CNT_W +: CNT_W] = CNT_W'(p1);
        bus.phase[2*CNT_W +: CNT_W] = CNT_W'(p2);
        bus.phase[3*CNT_W +: CNT_W] = CNT_W'(p3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time %0t, limit reached", $time);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N_LEGS; k++) m_ph[k] = 0;
        bus.en       = 1'b0;
        bus.kill     = 1'b0;
        bus.sync     = 1'b0;
        bus.period   = '0;
        bus.phase    = '0;
        bus.deadtime = '0;
        @(negedge clk);
        run_cycles(3);
        rst_n = 1'b1;
        run_cycles(2);

        // Basic DPS pattern, then a phase change mid-period that must wait for the wrap.
        bus.period = 16'd100;
        set_phase(0, 0, 50, 50);
        bus.en = 1'b1;
        run_cycles(250);
        step_to_cnt(40, 200);
        set_phase(25, 0, 50, 50);
        run_cycles(220);
        wait_idle(300);

        // Same pattern with 5 clocks of deadtime; stop requested at cnt 30.
        bus.deadtime = 8'd5;
        set_phase(0, 0, 50, 50);
        bus.en = 1'b1;
        run_cycles(250);
        step_to_cnt(30, 200);
        bus.en = 1'b0;
        wait_idle(200);
        run_cycles(3);

        // Period clamp to the minimum, then odd period with phases clamped to P-1.
        bus.deadtime = 8'd0;
        bus.period = 16'd3;
        bus.en = 1'b1;
        run_cycles(40);
        wait_idle(50);
        bus.period = 16'd101;
        set_phase(200, 0, 30, 200);
        bus.en = 1'b1;
        run_cycles(250);

        // Kill at cnt 10, restart, external resync at cnt 60 and at the wrap.
        step_to_cnt(10, 200);
        bus.kill = 1'b1;
        cycle();
        bus.kill = 1'b0;
        run_cycles(120);
        step_to_cnt(60, 200);
        bus.sync = 1'b1;
        cycle();
        bus.sync = 1'b0;
        run_cycles(60);
        step_to_cnt(100, 200);
        bus.sync = 1'b1;
        cycle();
        bus.sync = 1'b0;
        run_cycles(30);

        // Asynchronous reset while gates are active.
        for (int i = 0; i < 200 && bus.psm == '0; i++) cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_async_psm", 32'(bus.psm), 32'(0));
        chk("rst_async_run", 32'(bus.run), 32'(0));
        chk("rst_async_cnt", 32'(bus.cnt), 32'(0));
        m_state = 0;
        m_cnt = 0;
        m_P = 0;
        m_H = 0;
        for (int k = 0; k < N_LEGS; k++) m_ph[k] = 0;
        bus.en = 1'b0;
        @(negedge clk);
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(2);

        // Randomised segments: input churn, resyncs, kills and stop requests.
        for (int seg = 0; seg < 14; seg++) begin
            wait_idle(300);
            bus.deadtime = DT_W'($urandom_range(0, 10));
            bus.period   = CNT_W'($urandom_range(1, 48));
            for (int k = 0; k < N_LEGS; k++) bus.phase[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 60));
            bus.en = 1'b1;
            for (int i = 0; i < 250; i++) begin
                bus.sync = ($urandom_range(0, 39) == 0);
                bus.kill = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 29) == 0) bus.period = CNT_W'($urandom_range(1, 48));
                if ($urandom_range(0, 29) == 0) begin
                    for (int k = 0; k < N_LEGS; k++) bus.phase[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 60));
                end
                if ($urandom_range(0, 149) == 0) bus.en = ~bus.en;
                cycle();
            end
        end
        wait_idle(300);
        run_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
